// File: rtl/def.sv
// Shared memory data-port types, arbiter state encoding and arbiter defaults.
package def;

  localparam int DMEM_AW        = 14;
  localparam int STARVE_MAX_DEF = 8;
  localparam int LOCK_MAX_DEF   = 16;

  typedef struct packed {
    logic               WE;
    logic [3:0]         BE;
    logic [DMEM_AW-1:0] ADDR;
    logic [31:0]        WD;
  } dmem_w;

  typedef struct packed {
    logic [31:0] RD;
  } dmem_r;

  typedef enum logic {
    ARB,
    LOCK_B
  } arb_state;

endpackage

// File: rtl/arb_prio_sel.sv
// Grant select: A by default, B when A is idle, B when starved, B only while locked.
// Pure combinational, no state.
module arb_prio_sel
  import def::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  arb_state   state,
  input  logic [7:0] starve_cnt,
  input  logic       a_req,
  input  logic       b_req,
  output logic       a_gnt,
  output logic       b_gnt
);

  localparam logic [7:0] STARVE_C = 8'(STARVE_MAX);

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (state == LOCK_B) begin
      b_gnt = b_req;
    end else if (b_req && (starve_cnt == STARVE_C)) begin
      b_gnt = 1'b1;
    end else if (a_req) begin
      a_gnt = 1'b1;
    end else begin
      b_gnt = b_req;
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// Two-requester arbiter onto one memory data port: zero-latency grants, B starvation guard,
// B lock bursts, and read-response steering one cycle after the granted read.
module mem_port_arb
  import def::*;
#(
  parameter int D          = DMEM_AW,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int LOCK_MAX   = LOCK_MAX_DEF
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        A_REQ,
  input  logic        A_WE,
  input  logic [3:0]  A_BE,
  input  logic [31:0] A_ADDR,
  input  logic [31:0] A_WD,
  output logic        A_GNT,
  output logic        A_RVALID,
  output logic [31:0] A_RD,
  input  logic        B_REQ,
  input  logic        B_WE,
  input  logic [3:0]  B_BE,
  input  logic [31:0] B_ADDR,
  input  logic [31:0] B_WD,
  input  logic        B_LOCK,
  output logic        B_GNT,
  output logic        B_RVALID,
  output logic [31:0] B_RD,
  output dmem_w       M_W,
  input  dmem_r       M_R
);

  localparam logic [7:0] STARVE_C = 8'(STARVE_MAX);
  localparam logic [7:0] LOCK_C   = 8'(LOCK_MAX);
  localparam bit         LOCK_EN  = (LOCK_MAX > 1);

  arb_state   state_q, state_d;
  logic [7:0] starve_q, starve_d;
  logic [7:0] lock_q, lock_d;
  logic       pend_q, pend_d;
  logic       own_q, own_d;
  logic       a_req_g, b_req_g;
  logic       unused_addr;

  // Requests are masked while reset is held so no grant or memory access leaks out.
  assign a_req_g = A_REQ & RESET_N;
  assign b_req_g = B_REQ & RESET_N;

  arb_prio_sel #(
    .STARVE_MAX(STARVE_MAX)
  ) u_sel (
    .state     (state_q),
    .starve_cnt(starve_q),
    .a_req     (a_req_g),
    .b_req     (b_req_g),
    .a_gnt     (A_GNT),
    .b_gnt     (B_GNT)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ARB;
      starve_q <= 8'd0;
      lock_q   <= 8'd0;
      pend_q   <= 1'b0;
      own_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      lock_q   <= lock_d;
      pend_q   <= pend_d;
      own_q    <= own_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    case (state_q)
      ARB: begin
        if (B_GNT && B_LOCK && LOCK_EN) begin
          state_d = LOCK_B;
          lock_d  = 8'd1;
        end
      end
      LOCK_B: begin
        if (B_GNT) lock_d = lock_q + 8'd1;
        // Leave once this grant makes the burst LOCK_MAX long, or B releases the lock.
        if (!b_req_g || !B_LOCK || (lock_q >= LOCK_C - 8'd1)) begin
          state_d = ARB;
          lock_d  = 8'd0;
        end
      end
      default: begin
        state_d = ARB;
        lock_d  = 8'd0;
      end
    endcase
  end

  always_comb begin
    starve_d = 8'd0;
    if (b_req_g && !B_GNT) begin
      starve_d = (starve_q == STARVE_C) ? starve_q : starve_q + 8'd1;
    end
  end

  always_comb begin
    pend_d = 1'b0;
    own_d  = own_q;
    if (A_GNT && !A_WE) begin
      pend_d = 1'b1;
      own_d  = 1'b0;
    end else if (B_GNT && !B_WE) begin
      pend_d = 1'b1;
      own_d  = 1'b1;
    end
  end

  always_comb begin
    M_W = '0;
    if (A_GNT) begin
      M_W.WE   = A_WE;
      M_W.BE   = A_BE;
      M_W.ADDR = DMEM_AW'(A_ADDR[D-1:0]);
      M_W.WD   = A_WD;
    end else if (B_GNT) begin
      M_W.WE   = B_WE;
      M_W.BE   = B_BE;
      M_W.ADDR = DMEM_AW'(B_ADDR[D-1:0]);
      M_W.WD   = B_WD;
    end
  end

  assign A_RVALID = pend_q & ~own_q;
  assign B_RVALID = pend_q &  own_q;
  assign A_RD     = A_RVALID ? M_R.RD : 32'd0;
  assign B_RD     = B_RVALID ? M_R.RD : 32'd0;

  assign unused_addr = ^{A_ADDR[31:D], B_ADDR[31:D]};

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb with a byte-enabled one-cycle-latency memory model.
module tb_mem_port_arb;
  import def::*;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        A_REQ, A_WE, B_REQ, B_WE, B_LOCK;
  logic [3:0]  A_BE, B_BE;
  logic [31:0] A_ADDR, A_WD, B_ADDR, B_WD;
  logic        A_GNT, A_RVALID, B_GNT, B_RVALID;
  logic [31:0] A_RD, B_RD;
  dmem_w       M_W;
  dmem_r       M_R;

  logic [31:0] mem [0:255];
  logic [31:0] mrd;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  mem_port_arb dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_BE(A_BE), .A_ADDR(A_ADDR), .A_WD(A_WD),
    .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_RD(A_RD),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_BE(B_BE), .B_ADDR(B_ADDR), .B_WD(B_WD), .B_LOCK(B_LOCK),
    .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_RD(B_RD),
    .M_W(M_W), .M_R(M_R)
  );

  always @(posedge CLK) begin
    mrd <= mem[M_W.ADDR[7:0]];
    if (M_W.WE) begin
      for (int b = 0; b < 4; b++)
        if (M_W.BE[b]) mem[M_W.ADDR[7:0]][8*b +: 8] <= M_W.WD[8*b +: 8];
    end
  end
  assign M_R.RD = mrd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    A_REQ = 0; A_WE = 0; A_BE = 0; A_ADDR = 0; A_WD = 0;
    B_REQ = 0; B_WE = 0; B_BE = 0; B_ADDR = 0; B_WD = 0; B_LOCK = 0;
  endtask

  initial begin
    logic pa, pb, ea, eb;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h10] = 32'hAAAA5555;
    mem[8'h20] = 32'h12345678;
    idle_inputs();

    // Reset with both requesters active: no grants, memory port idle.
    RESET_N = 0;
    A_REQ = 1; A_ADDR = 32'h10; A_BE = 4'hF; A_WD = 32'h11111111;
    B_REQ = 1; B_ADDR = 32'h20; B_BE = 4'hF; B_WD = 32'h22222222;
    tick(); tick();
    @(negedge CLK);
    chk("rst_a_gnt", A_GNT, 0);
    chk("rst_b_gnt", B_GNT, 0);
    chk("rst_m_w", M_W, 0);
    chk("rst_a_rv", A_RVALID, 0);
    chk("rst_b_rv", B_RVALID, 0);

    // Both reading continuously: A x8, B once, repeat.
    tick();
    RESET_N = 1;
    A_WD = 0; B_WD = 0;
    pa = 0; pb = 0;
    for (int i = 0; i < 18; i++) begin
      eb = (i == 8) || (i == 17);
      ea = !eb;
      @(negedge CLK);
      chk("starve_a_gnt", A_GNT, ea);
      chk("starve_b_gnt", B_GNT, eb);
      chk("starve_both", A_GNT & B_GNT, 0);
      chk("starve_addr", M_W.ADDR, eb ? 32'h20 : 32'h10);
      chk("starve_a_rv", A_RVALID, pa);
      chk("starve_a_rd", A_RD, pa ? 32'hAAAA5555 : 32'd0);
      chk("starve_b_rv", B_RVALID, pb);
      chk("starve_b_rd", B_RD, pb ? 32'h12345678 : 32'd0);
      pa = ea; pb = eb;
      tick();
    end
    idle_inputs();
    @(negedge CLK);
    chk("tail_b_rv", B_RVALID, 1);
    chk("tail_b_rd", B_RD, 32'h12345678);
    chk("idle_m_w", M_W, 0);
    tick();

    // A read 0x10, then B read 0x20 on the next cycle.
    A_REQ = 1; A_ADDR = 32'h10;
    @(negedge CLK);
    chk("ab_a_gnt", A_GNT, 1);
    tick();
    A_REQ = 0; B_REQ = 1; B_ADDR = 32'h20;
    @(negedge CLK);
    chk("ab_b_gnt", B_GNT, 1);
    chk("ab_a_rv1", A_RVALID, 1);
    chk("ab_a_rd1", A_RD, 32'hAAAA5555);
    chk("ab_b_rv1", B_RVALID, 0);
    chk("ab_b_rd1", B_RD, 0);
    tick();
    idle_inputs();
    @(negedge CLK);
    chk("ab_b_rv2", B_RVALID, 1);
    chk("ab_b_rd2", B_RD, 32'h12345678);
    chk("ab_a_rv2", A_RVALID, 0);
    chk("ab_a_rd2", A_RD, 0);
    tick();

    // Partial write then read-back of the same word.
    A_REQ = 1; A_WE = 1; A_BE = 4'b0011; A_ADDR = 32'h4; A_WD = 32'hDEADBEEF;
    @(negedge CLK);
    chk("wr_a_gnt", A_GNT, 1);
    chk("wr_m_we", M_W.WE, 1);
    chk("wr_m_be", M_W.BE, 4'b0011);
    chk("wr_m_wd", M_W.WD, 32'hDEADBEEF);
    tick();
    A_WE = 0; A_BE = 4'hF; A_WD = 0;
    @(negedge CLK);
    chk("wr_no_rv", A_RVALID, 0);
    chk("wr_rd_gnt", A_GNT, 1);
    tick();
    idle_inputs();
    @(negedge CLK);
    chk("raw_rv", A_RVALID, 1);
    chk("raw_rd", A_RD, 32'h0000BEEF);
    tick();

    // Locked B write burst against a continuously requesting A.
    A_REQ = 1; A_ADDR = 32'h10;
    B_REQ = 1; B_WE = 1; B_BE = 4'hF; B_ADDR = 32'h30; B_WD = 32'h5A5A0000; B_LOCK = 1;
    for (int i = 0; i < 26; i++) begin
      ea = (i < 8) || (i >= 24);
      @(negedge CLK);
      chk("lock_a_gnt", A_GNT, ea);
      chk("lock_b_gnt", B_GNT, !ea);
      chk("lock_we", M_W.WE, !ea);
      chk("lock_b_rv", B_RVALID, 0);
      tick();
      B_WD = B_WD + 1;
    end
    idle_inputs();
    tick();

    // Dropping B_LOCK releases the lock one cycle later.
    B_REQ = 1; B_LOCK = 1; B_WE = 1; B_ADDR = 32'h40;
    @(negedge CLK);
    chk("rel_b_enter", B_GNT, 1);
    tick();
    A_REQ = 1; B_LOCK = 0;
    @(negedge CLK);
    chk("rel_b_last", B_GNT, 1);
    chk("rel_a_held", A_GNT, 0);
    tick();
    @(negedge CLK);
    chk("rel_a_after", A_GNT, 1);
    chk("rel_b_after", B_GNT, 0);
    idle_inputs();
    tick();

    // B withdrawing its request inside a lock: A still waits one cycle.
    B_REQ = 1; B_LOCK = 1; B_WE = 1; B_ADDR = 32'h41;
    @(negedge CLK);
    chk("wd_b_enter", B_GNT, 1);
    tick();
    A_REQ = 1; B_REQ = 0;
    @(negedge CLK);
    chk("wd_a_blocked", A_GNT, 0);
    chk("wd_b_none", B_GNT, 0);
    tick();
    @(negedge CLK);
    chk("wd_a_after", A_GNT, 1);
    idle_inputs();
    tick();

    // Reset in the cycle after a B read grant discards its response.
    B_REQ = 1; B_ADDR = 32'h20;
    @(negedge CLK);
    chk("mid_b_gnt", B_GNT, 1);
    tick();
    idle_inputs();
    RESET_N = 0;
    @(negedge CLK);
    chk("mid_b_rv", B_RVALID, 0);
    chk("mid_b_rd", B_RD, 0);
    tick();
    RESET_N = 1;
    @(negedge CLK);
    chk("post_b_rv", B_RVALID, 0);
    chk("post_a_rv", A_RVALID, 0);
    chk("post_m_w", M_W, 0);
    chk("post_gnt", {30'd0, A_GNT, B_GNT}, 0);
    tick();
    A_REQ = 1; A_ADDR = 32'h10; B_REQ = 1; B_ADDR = 32'h20;
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      chk("post_b_gnt", B_GNT, (i == 8));
      chk("post_a_gnt", A_GNT, (i != 8));
      tick();
    end
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 Parameter: D, 14, word-address bits forwarded to memory.
REQ-002 Parameter: STARVE_MAX, 8, consecutive denied cycles before requester B is force-granted (range 1..255).
REQ-003 Parameter: LOCK_MAX, 16, maximum consecutive locked grants to B (range 1..255).
REQ-004 CLK  in  1  single clock, all state on rising edge.
REQ-005 RESET_N  in  1  asynchronous, active-low reset.
REQ-006 A_REQ / A_WE / A_BE / A_ADDR / A_WD  in  1/1/4/32/32  requester A (core LSU): request, write enable, byte enables, word address, write data.
REQ-007 A_GNT  out  1  request A accepted this cycle; A_RVALID  out  1  A read data valid; A_RD  out  32  A read data.
REQ-008 B_REQ / B_WE / B_BE / B_ADDR / B_WD / B_LOCK  in  1/1/4/32/32/1  requester B (loader/debug), B_LOCK requests burst ownership.
REQ-009 B_GNT / B_RVALID / B_RD  out  1/1/32  as for A.
REQ-010 M_W  out  def::dmem_w  memory data-port request (WE, BE, ADDR, WD).
REQ-011 M_R  in  def::dmem_r  memory data-port read data (RD), valid exactly one cycle after the request cycle.

Function
REQ-012 At most one of A_GNT, B_GNT SHALL be high in any cycle; a grant SHALL only be issued to a requester whose REQ is high.
REQ-013 Grants SHALL be combinational from the REQs and registered state; a granted request SHALL be presented on M_W in the same cycle (zero added latency).
REQ-014 M_W SHALL carry the granted requester's WE, BE, ADDR, WD; with no grant, M_W.WE=0, BE=0, ADDR=0, WD=0.
REQ-015 FSM states: ARB, LOCK_B; reset state ARB.
REQ-016 In ARB: if starve_cnt==STARVE_MAX and B_REQ, grant B; else if A_REQ, grant A; else if B_REQ, grant B.
REQ-017 starve_cnt SHALL increment (saturating at STARVE_MAX) each cycle B_REQ=1 and B_GNT=0, and clear to 0 on any cycle with B_GNT=1 or B_REQ=0.
REQ-018 In ARB, a B grant with B_LOCK=1 SHALL transition to LOCK_B and load lock_cnt=1.
REQ-019 In LOCK_B: grant B whenever B_REQ=1, never grant A; lock_cnt increments per B grant.
REQ-020 LOCK_B SHALL return to ARB the cycle after B_LOCK=0, B_REQ=0, or lock_cnt reaching LOCK_MAX; A is grantable in that next cycle.
REQ-021 Each granted read (WE=0) SHALL set a one-bit response-owner register and a pending flag; the next cycle the owner's RVALID=1 and its RD=M_R.RD; the other RD SHALL be 0.
REQ-022 Granted writes SHALL produce no RVALID.
REQ-023 Back-to-back reads from alternating requesters SHALL each return correctly on consecutive cycles (full throughput, one access per cycle).
REQ-024 Write followed next cycle by read of the same address SHALL return the written data (memory ordering, no reordering by the arbiter).

Reset
REQ-025 RESET_N low SHALL immediately force state=ARB, starve_cnt=0, lock_cnt=0, pending=0, A_RVALID=B_RVALID=0.
REQ-026 Reset asserted mid-read SHALL discard the in-flight response; no RVALID after reset release until a new grant.
REQ-027 During reset, A_GNT=B_GNT=0 and M_W idle (REQ-014 values).

Structure
REQ-028 def::dmem_w, def::dmem_r and an arbiter state enum def::arb_state SHALL reside in the shared def package; STARVE_MAX and LOCK_MAX defaults as package constants.
REQ-029 Grant-select logic SHALL be one sub-module, arb_prio_sel (pure combinational priority/starvation select); everything else in mem_port_arb.

Verification
REQ-030 A_REQ and B_REQ held high continuously, both reads -> A granted 8 cycles, B granted cycle 9, pattern repeats; no cycle with both grants.
REQ-031 A read of 0x10 then B read of 0x20 next cycle, memory preloaded 0x10=0xAAAA5555, 0x20=0x12345678 -> A_RVALID with 0xAAAA5555 at t+1, B_RVALID with 0x12345678 at t+2.
REQ-032 B_LOCK=1 burst of 20 writes with A_REQ high -> B granted 16 consecutive cycles, A granted the 17th cycle.
REQ-033 A write 0xDEADBEEF BE=0011 to 0x4 (previously 0), A read 0x4 next cycle -> A_RD=0x0000BEEF.
REQ-034 RESET_N dropped in the cycle after a B read grant -> B_RVALID stays 0; after release, idle outputs and starve_cnt=0.
